// File: rtl/shift_deser.sv
`default_nettype none
// ============================================================================
//  Module   : shift_deser
//  Purpose  : Serial-to-parallel deserialiser. Bits are shifted into an
//             internal register from either end (mixable per bit); each
//             completed word is handed to a registered output with a
//             valid/ready handshake. Completed words that arrive while the
//             output is still occupied are dropped and flagged sticky.
//  Option   : define SHIFT_DESER_PARITY_EN to append one even-parity bit to
//             every word (checked, not stored); without it parity_err is 0.
//  Ports    : clk        - clock, rising edge
//             reset      - asynchronous, active-low reset
//             cntrl[1:0] - 00 hold, 01 shift in at MSB, 10 shift in at LSB,
//                          11 abort current word and clear flags
//             sin        - serial data bit
//             q          - delivered word (registered)
//             q_valid    - q holds an undelivered word
//             q_ready    - consumer takes q on an edge where q_valid=1
//             overrun    - sticky: a completed word was dropped
//             parity_err - parity mismatch on the word in q
//  Revision : 1.0  initial release
// ============================================================================
module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cntrl,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_valid;
  logic               r_overrun;

  logic               w_shift;
  logic               w_data_bit;
  logic               w_last_data;
  logic               w_complete;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sr_next;
  logic [WIDTH-1:0]   w_word;

  assign w_shift     = (cntrl == 2'b01) || (cntrl == 2'b10);
  assign w_sr_next   = (cntrl == 2'b01) ? {sin, r_sr[WIDTH-1:1]}
                                        : {r_sr[WIDTH-2:0], sin};
  assign w_data_bit  = w_shift && (r_state == ST_DATA);
  assign w_last_data = w_data_bit && (r_cnt == c_last);
  // The output slot is free if empty or being emptied on this same edge.
  assign w_accept    = !r_q_valid || q_ready;

`ifdef SHIFT_DESER_PARITY_EN
  logic r_parity_err;
  logic w_perr;

  // Word completes on the parity bit; data already sits in r_sr.
  assign w_complete = w_shift && (r_state == ST_PARITY);
  assign w_word     = r_sr;
  assign w_perr     = ^{r_sr, sin};
  assign parity_err = r_parity_err;
`else
  // Word completes on the last data bit; deliver the post-shift value.
  assign w_complete = w_last_data;
  assign w_word     = w_sr_next;
  assign parity_err = 1'b0;
`endif

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign overrun = r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_DATA;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_q          <= '0;
      r_q_valid    <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else if (cntrl == 2'b11) begin
      // Abort: collection state and flags clear, delivered word untouched.
      r_state      <= ST_DATA;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_overrun    <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_data_bit) begin
        r_sr <= w_sr_next;
        if (w_last_data) begin
          r_cnt <= '0;
`ifdef SHIFT_DESER_PARITY_EN
          r_state <= ST_PARITY;
`else
          r_state <= ST_DATA;
`endif
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

`ifdef SHIFT_DESER_PARITY_EN
      if (w_complete) begin
        r_state <= ST_DATA;
      end
`endif

      // Output handshake runs regardless of hold/shift.
      if (w_complete) begin
        if (w_accept) begin
          r_q          <= w_word;
          r_q_valid    <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
          r_parity_err <= w_perr;
`endif
        end else begin
          r_overrun    <= 1'b1;
        end
      end else if (r_q_valid && q_ready) begin
        r_q_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
